// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between the ALU/load
// writeback path (requester 0) and the multi-cycle mul/div unit (requester 1).
module rf_write_arbiter #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [WIDTH-1:0]  req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [WIDTH-1:0]  req1_data,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              we_o,
  output logic [ADDR_W-1:0] wa_o,
  output logic [WIDTH-1:0]  wd_o,
  output logic              hazard1_o,
  output logic              hazard2_o,
  output logic              last_gnt_o
);

  logic              gnt0;
  logic              gnt1;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [WIDTH-1:0]  sel_data;
  logic [ADDR_W-1:0] rd_addr [2];
  logic [1:0]        hazard;

  // Under contention the requester not granted last wins; readys stay low in reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_gnt_o;
        gnt1 = ~last_gnt_o;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign xfer       = gnt0 | gnt1;
  assign sel_addr   = gnt1 ? req1_addr : req0_addr;
  assign sel_data   = gnt1 ? req1_data : req0_data;

  // Writes to $0 still consume a grant but never raise the write enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_o       <= 1'b0;
      wa_o       <= '0;
      wd_o       <= '0;
      last_gnt_o <= 1'b1;
    end else if (xfer) begin
      we_o       <= |sel_addr;
      wa_o       <= sel_addr;
      wd_o       <= sel_data;
      last_gnt_o <= gnt1;
    end else begin
      we_o       <= 1'b0;
    end
  end

  assign rd_addr[0] = rd_addr1;
  assign rd_addr[1] = rd_addr2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_hazard
      assign hazard[gi] = we_o && (rd_addr[gi] == wa_o);
    end
  endgenerate

  assign hazard1_o = hazard[0];
  assign hazard2_o = hazard[1];

endmodule
